// File: rtl/spi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// spi_pkg : shared types and constants for the serial register bank
// Rev 1.0
// ---------------------------------------------------------------
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CMD      = 2'd1,
    DATA     = 2'd2,
    DATA_IGN = 2'd3
  } spi_state_t;

  localparam int CMD_RW_BIT = 7;
  localparam int CMD_ADDR_W = 7;
  localparam int BYTE_W     = 8;

endpackage
`default_nettype wire

// File: rtl/spi_sync.sv
`default_nettype none
// ---------------------------------------------------------------
// spi_sync : 2-FF synchroniser with registered rise/fall pulses
// Rev 1.0
// ---------------------------------------------------------------
module spi_sync (
  input  logic iclk,
  input  logic rstn,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [2:0] sh;

  // q is the third stage so it lines up with the edge pulses of a sibling instance
  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      sh   <= 3'b000;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sh   <= {sh[1:0], d};
      rise <= sh[1] & ~sh[2];
      fall <= ~sh[1] & sh[2];
    end
  end

  assign q = sh[2];

endmodule
`default_nettype wire

// File: rtl/spi_reg_bank.sv
`default_nettype none
// ---------------------------------------------------------------
// spi_reg_bank : serial configuration slave with burst and readback
// Rev 1.0
// ---------------------------------------------------------------
module spi_reg_bank
  import spi_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 8
) (
  input  logic                       iclk,
  input  logic                       rstn,
  input  logic                       sclk,
  input  logic                       csn,
  input  logic                       serial_in,
  output logic                       serial_out,
  input  logic [DATA_W-1:0]          status_in,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       addr_err
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [CMD_ADDR_W:0] NUM_REGS_L = (CMD_ADDR_W + 1)'(NUM_REGS);
  localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(NUM_REGS - 1);

  logic sclk_q, sclk_rise, sclk_fall;
  logic csn_q, csn_rise, csn_fall;
  logic sin_q, sin_rise, sin_fall;

  spi_sync u_sync_sclk (.iclk(iclk), .rstn(rstn), .d(sclk),
                        .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync u_sync_csn  (.iclk(iclk), .rstn(rstn), .d(csn),
                        .q(csn_q), .rise(csn_rise), .fall(csn_fall));
  spi_sync u_sync_sin  (.iclk(iclk), .rstn(rstn), .d(serial_in),
                        .q(sin_q), .rise(sin_rise), .fall(sin_fall));

  logic unused_sync;
  assign unused_sync = ^{sclk_q, csn_q, sin_rise, sin_fall};

  spi_state_t         state, state_next;
  logic [2:0]         bit_cnt;
  logic [BYTE_W-1:0]  rx_sh, tx_sh;
  logic [IDX_W-1:0]   ptr;
  logic               rw;
  logic [DATA_W-1:0]  regs [NUM_REGS];

  logic [BYTE_W-1:0]     rx_byte;
  logic [CMD_ADDR_W-1:0] cmd_addr;
  logic [IDX_W-1:0]      cmd_idx, ptr_wrap, load_idx;
  logic                  byte_done, addr_bad;
  logic                  err_pulse, commit, load_tx, tx_zero, ptr_load, ptr_inc;
  logic [BYTE_W-1:0]     load_val;

  // LSB first: each new bit enters at the top and the byte settles after eight shifts
  assign rx_byte   = {sin_q, rx_sh[BYTE_W-1:1]};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);
  assign cmd_addr  = rx_byte[CMD_ADDR_W-1:0];
  assign cmd_idx   = rx_byte[IDX_W-1:0];
  assign addr_bad  = {1'b0, cmd_addr} >= NUM_REGS_L;
  assign ptr_wrap  = (ptr == LAST_IDX) ? '0 : ptr + IDX_W'(1);
  assign load_val  = tx_zero ? '0 : ((load_idx == '0) ? status_in : regs[load_idx]);

  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // csn_rise is tested before byte_done so a coincident end-of-frame drops the byte
  always_comb begin
    state_next = state;
    err_pulse  = 1'b0;
    commit     = 1'b0;
    load_tx    = 1'b0;
    tx_zero    = 1'b0;
    ptr_load   = 1'b0;
    ptr_inc    = 1'b0;
    load_idx   = ptr;
    case (state)
      IDLE: if (csn_fall) state_next = CMD;
      CMD: begin
        if (csn_rise) begin
          state_next = IDLE;
        end else if (byte_done) begin
          if (addr_bad) begin
            state_next = DATA_IGN;
            err_pulse  = 1'b1;
            load_tx    = 1'b1;
            tx_zero    = 1'b1;
          end else begin
            state_next = DATA;
            ptr_load   = 1'b1;
            load_tx    = rx_byte[CMD_RW_BIT];
            load_idx   = cmd_idx;
          end
        end
      end
      DATA: begin
        if (csn_rise) begin
          state_next = IDLE;
        end else if (byte_done) begin
          ptr_inc = 1'b1;
          if (rw) begin
            load_tx  = 1'b1;
            load_idx = ptr_wrap;
          end else begin
            commit = (ptr != '0);
          end
        end
      end
      DATA_IGN: if (csn_rise) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt    <= 3'd0;
      rx_sh      <= '0;
      tx_sh      <= '0;
      ptr        <= '0;
      rw         <= 1'b0;
      serial_out <= 1'b0;
      wr_strobe  <= '0;
      addr_err   <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else begin
      wr_strobe <= '0;
      addr_err  <= err_pulse;
      if (state_next == IDLE) begin
        bit_cnt    <= 3'd0;
        rx_sh      <= '0;
        tx_sh      <= '0;
        serial_out <= 1'b0;
      end else begin
        if (sclk_rise) begin
          bit_cnt <= bit_cnt + 3'd1;
          rx_sh   <= rx_byte;
        end
        if (sclk_fall) begin
          serial_out <= tx_sh[0];
          tx_sh      <= tx_sh >> 1;
        end
        if (load_tx) tx_sh <= load_val;
        if (ptr_load) begin
          ptr <= cmd_idx;
          rw  <= rx_byte[CMD_RW_BIT];
        end
        if (ptr_inc) ptr <= ptr_wrap;
        if (commit) begin
          regs[ptr]      <= rx_byte;
          wr_strobe[ptr] <= 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    if (k == 0) begin : g_status
      assign regs_out[DATA_W-1:0] = '0;
    end else begin : g_reg
      assign regs_out[k*DATA_W +: DATA_W] = regs[k];
    end
  end

endmodule
`default_nettype wire
